// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register completer.
package apb_pkg;
   localparam int REG_IDX_W           = 3;
   localparam int REG_COUNT           = 8;
   localparam int MAILBOX_IDX_DEFAULT = 7;

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} apb_state_t;

   // Everything the completer presents back to the bus, registered as one unit.
   typedef struct packed {
      logic       pready;
      logic       pslverr;
      logic [7:0] prdata;
      logic       wr_commit;
   } apb_rsp_t;

   function automatic logic xfer_err(input logic wr, input logic hi_set,
                                     input logic [REG_IDX_W-1:0] idx,
                                     input logic [REG_IDX_W-1:0] mailbox);
      return hi_set || (wr && idx != mailbox);
   endfunction
endpackage

// File: rtl/apb_reg_completer.sv
// APB completer in front of the 8x8 register file: reads any register,
// writes only the mailbox, with a programmable number of wait states.
module apb_reg_completer
   import apb_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 0,
   parameter int MAILBOX_IDX = MAILBOX_IDX_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 psel,
   input  logic                 penable,
   input  logic                 pwrite,
   input  logic [ADDR_W-1:0]    paddr,
   input  logic [7:0]           pwdata,
   output logic [7:0]           prdata,
   output logic                 pready,
   output logic                 pslverr,
   output logic                 apb_op,
   output logic                 apb_wr_en,
   output logic [7:0]           apb_data,
   output logic [REG_IDX_W-1:0] rf_read_addr,
   input  logic [7:0]           rf_read_data
);
   localparam logic [REG_IDX_W-1:0] MB        = REG_IDX_W'(MAILBOX_IDX % REG_COUNT);
   localparam logic [3:0]           WAIT_INIT = 4'(WAIT_STATES);

   apb_state_t        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [7:0]        wdata_q, wdata_d;
   apb_rsp_t          rsp_q, rsp_d;

   logic              cur_wr, cur_err;
   logic [ADDR_W-1:0] cur_addr;
   apb_rsp_t          fire;

   // With zero wait states the response is formed in the setup cycle, so the
   // live bus fields are used there; ACCESS works from the captured copy.
   assign cur_wr       = (state_q == IDLE) ? pwrite : pwrite_q;
   assign cur_addr     = (state_q == IDLE) ? paddr  : paddr_q;
   assign cur_err      = xfer_err(cur_wr, |cur_addr[ADDR_W-1:REG_IDX_W],
                                  cur_addr[REG_IDX_W-1:0], MB);
   assign rf_read_addr = cur_addr[REG_IDX_W-1:0];

   assign fire = '{pready:    1'b1,
                   pslverr:   cur_err,
                   prdata:    (!cur_wr && !cur_err) ? rf_read_data : 8'h00,
                   wr_commit: cur_wr && !cur_err};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      wdata_d  = wdata_q;
      rsp_d    = '0;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d  = ACCESS;
               cnt_d    = WAIT_INIT;
               pwrite_d = pwrite;
               paddr_d  = paddr;
               wdata_d  = pwdata;
               if (WAIT_STATES == 0) rsp_d = fire;
            end
         end
         ACCESS: begin
            if (!psel) begin
               // master abandoned the transfer: nothing is committed
               state_d = IDLE;
               cnt_d   = '0;
            end else if (rsp_q.pready) begin
               if (penable) state_d = IDLE;
               else         rsp_d   = rsp_q;
            end else if (cnt_q == 4'd1) begin
               rsp_d = fire;
               cnt_d = '0;
            end else if (cnt_q > 4'd1) begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         wdata_q  <= '0;
         rsp_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         wdata_q  <= wdata_d;
         rsp_q    <= rsp_d;
      end
   end

   assign pready    = rsp_q.pready;
   assign pslverr   = rsp_q.pslverr;
   assign prdata    = rsp_q.prdata;
   assign apb_op    = rsp_q.wr_commit;
   assign apb_wr_en = rsp_q.wr_commit;
   assign apb_data  = wdata_q;
endmodule

// File: doc/apb_reg_completer.md
# apb_reg_completer

APB completer (slave) that sits between the APB bus and the I2C controller's 8×8-bit register file, driving the file's APB write path (`apb_op`/`apb_data`) and returning register contents on APB reads. Writes from the bus land only in the mailbox register (index 7). Reads may target any of registers 0–7. Programmable wait states let the bench and the SoC exercise PREADY back-pressure. All bus-side outputs are registered.

## Interface
Parameters:
- `ADDR_W`, 8: PADDR width. Bits [2:0] select the register; any higher bit set is an invalid address.
- `WAIT_STATES`, 0: access-phase cycles with PREADY low before completion, range 0–15.
- `MAILBOX_IDX`, 7: only register index writable from APB.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous active-high reset
- `psel`  in  1  APB select
- `penable`  in  1  APB access-phase strobe
- `pwrite`  in  1  1 = write, 0 = read
- `paddr`  in  ADDR_W  register address
- `pwdata`  in  8  write data
- `prdata`  out  8  read data, nonzero only while `pready`=1 on a valid read
- `pready`  out  1  transfer-complete
- `pslverr`  out  1  error response, only asserted with `pready`
- `apb_op`  out  1  to regfile `apb_op`, high for exactly the commit cycle
- `apb_wr_en`  out  1  ORed into regfile `reg_write_en` at top level, same cycle as `apb_op`
- `apb_data`  out  8  to regfile `apb_data`, the captured `pwdata`
- `rf_read_addr`  out  3  to a regfile read port
- `rf_read_data`  in  8  from the same regfile read port (combinational)

## Operation
- FSM states: IDLE, ACCESS.
- **IDLE.** On `psel`=1, `penable`=0 (setup), capture `pwrite`, `paddr`, `pwdata`, then go to ACCESS. Load `cnt` with `WAIT_STATES`.
  - If `WAIT_STATES`=0, set `pready`<=1 on that same edge.
  - All other input combinations: stay in IDLE, outputs 0.
- **ACCESS.**
  - While `pready`=0 and `cnt`>1: decrement `cnt`.
  - When `cnt`=1: set `pready`<=1, `cnt`<=0.
  - With `pready`=1 and `psel`&`penable`=1: the transfer completes on this edge. Clear `pready`, `pslverr`, `prdata`, `apb_op`, `apb_wr_en`, then go to IDLE.
- **Error.** `err` = (`paddr`[ADDR_W-1:3]≠0) OR (write AND `paddr`[2:0]≠MAILBOX_IDX).
- **Signals registered alongside `pready`** (all set at the edge that raises `pready`):
  - `pslverr`<=`err`.
  - `prdata`<= read & !`err` ? `rf_read_data` : 0.
  - `apb_op`=`apb_wr_en`<= write & !`err`.
- **Error writes** never reach the regfile.
- `rf_read_addr` = captured `paddr`[2:0], held stable throughout ACCESS.
- **Regfile priority.** The regfile gives `apb_op` priority over a same-cycle core write. A core write to reg 7 in the commit cycle is lost. This is defined behaviour, and firmware arbitrates.
- **Protocol violation.** `psel` drops while in ACCESS: return to IDLE next edge, clear all outputs, no regfile write.
- **Reset.** Reset in any state: next edge gives IDLE. `cnt`, `prdata`, `pready`, `pslverr`, `apb_op`, `apb_wr_en`, `apb_data` all become 0. An in-flight write is discarded.

## Timing
- Setup at cycle T gives `pready`=1 during cycle T+1+`WAIT_STATES`. The transfer completes at the end of that cycle.
- The regfile write occurs on the completion edge, the same edge the master samples `pready`. New reg 7 value is readable from cycle T+2+`WAIT_STATES`.
- Read data reflects the regfile contents at the edge that raises `pready`. Core writes landing after that edge are not seen.
- Back-to-back transfers: the completion edge returns to IDLE, and the next setup cycle is accepted immediately. Zero idle cycles are required.
- `pready`, `pslverr`, `apb_op`, and `apb_wr_en` are each high for exactly one cycle per transfer.

## Structure
- Shared package `apb_pkg` holds:
  - `apb_state_t` enum {IDLE, ACCESS}
  - `REG_IDX_W`=3, `REG_COUNT`=8, `MAILBOX_IDX_DEFAULT`=7
- Single module, no sub-modules. The wait counter is a 4-bit register inside the FSM.
- Top level instantiates `apb_reg_completer` next to `regfile`:
  - `apb_op`/`apb_data` connect directly to the regfile.
  - `apb_wr_en` is ORed with the core's `reg_write_en`.

## Test plan
- **Zero-wait write**, `WAIT_STATES`=0, write 0xA5 to addr 7 → `pready`=1 at T+1, `pslverr`=0, reg 7 reads 0xA5 at T+2.
- **Wait-state read**, `WAIT_STATES`=3, core preloads reg 2=0x3C, APB read addr 2 → `pready` low T+1..T+3, high T+4, `prdata`=0x3C.
- **Bad write target**, write 0xFF to addr 3 → `pslverr`=1 with `pready`, `apb_op` stays 0, reg 3 unchanged.
- **Out-of-range read**, read addr 0x12 → `pslverr`=1, `prdata`=0.
- **Back-to-back**, write 0x11 to addr 7, then read addr 7 in the next setup cycle with no gap → read returns 0x11, `apb_op` pulsed exactly once.
- **Reset mid-access**, `WAIT_STATES`=5, write 0x77 to addr 7, `rst` asserted at T+2 → `pready`, `apb_op`, `prdata` stay 0, reg 7 unchanged, FSM in IDLE and accepts the next setup.
